// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle between the pipeline stages, the arbiter and the RAM.
// slave = arbiter side, master = stage/RAM side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              mem_req;
   logic              mem_rw;
   logic              mem_size;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] if_rdata;
   logic              if_done;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_done;
   logic              if_stall;
   logic              mem_stall;
   logic              ram_en;
   logic              ram_rw;
   logic              ram_size;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  if_req, if_addr, mem_req, mem_rw, mem_size,
      input  mem_addr, mem_wdata, ram_rdata,
      output if_rdata, if_done, mem_rdata, mem_done,
      output if_stall, mem_stall,
      output ram_en, ram_rw, ram_size, ram_addr, ram_wdata
   );

   modport master (
      output if_req, if_addr, mem_req, mem_rw, mem_size,
      output mem_addr, mem_wdata, ram_rdata,
      input  if_rdata, if_done, mem_rdata, mem_done,
      input  if_stall, mem_stall,
      input  ram_en, ram_rw, ram_size, ram_addr, ram_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// IF/MEM shared memory port arbiter: IDLE -> BUSY(MEM_LAT) -> DONE.
// Optional macro ARB_ROUND_ROBIN_EN alternates grants under contention.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input logic clk,
   input logic reset,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic       OWN_IF   = 1'b0;
   localparam logic       OWN_MEM  = 1'b1;
   localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              owner_q;
   logic              en_q;
   logic              rw_q;
   logic              size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] mem_rdata_q;
   logic              if_done_q;
   logic              mem_done_q;
   logic              gnt_any;
   logic              gnt_mem;

   assign gnt_any = bus.mem_req | bus.if_req;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_q;
   // Under contention the side that was not served last wins.
   assign gnt_mem = bus.mem_req & (~bus.if_req | (last_q == OWN_IF));
`else
   assign gnt_mem = bus.mem_req;
`endif

   // Transaction sequencer with registered RAM controls and results.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         owner_q     <= OWN_IF;
         en_q        <= 1'b0;
         rw_q        <= 1'b0;
         size_q      <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_q      <= OWN_IF;
`endif
      end else begin
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (gnt_any) begin
                  owner_q <= gnt_mem;
                  addr_q  <= gnt_mem ? bus.mem_addr : bus.if_addr;
                  rw_q    <= gnt_mem & bus.mem_rw;
                  size_q  <= gnt_mem & bus.mem_size;
                  wdata_q <= gnt_mem ? bus.mem_wdata : '0;
                  cnt_q   <= CNT_INIT;
                  en_q    <= 1'b1;
                  state_q <= BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                  last_q  <= gnt_mem;
`endif
               end
            end
            BUSY: begin
               if (cnt_q == 4'd0) begin
                  en_q       <= 1'b0;
                  state_q    <= DONE;
                  if_done_q  <= (owner_q == OWN_IF);
                  mem_done_q <= (owner_q == OWN_MEM);
                  if (owner_q == OWN_IF) begin
                     if_rdata_q <= bus.ram_rdata;
                  end else if (!rw_q) begin
                     mem_rdata_q <= size_q
                        ? {{(DATA_W-8){1'b0}}, bus.ram_rdata[7:0]}
                        : bus.ram_rdata;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.ram_en    = en_q;
   assign bus.ram_rw    = rw_q;
   assign bus.ram_size  = size_q;
   assign bus.ram_addr  = addr_q;
   assign bus.ram_wdata = wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.mem_rdata = mem_rdata_q;
   assign bus.if_done   = if_done_q;
   assign bus.mem_done  = mem_done_q;

   // Stalls are quiet while reset is held so every output reads 0.
   assign bus.if_stall  = bus.if_req & ~if_done_q & ~reset;
   assign bus.mem_stall = bus.mem_req & ~mem_done_q & ~reset;
endmodule
